// File: rtl/fb_window_renderer.sv
// fb_window_renderer
//
// Pixel-colour stage that sits behind the 640x480 display timing generator.
// For every pixel inside a 256x256 window it reads an RGB565 word from an
// external synchronous framebuffer RAM. Other active pixels get a border
// colour, and blanking pixels are black. HSYNC, VSYNC and DEN travel through
// the same number of registers as the colour, so all of them stay aligned at
// the LCD pins. Scroll offsets are taken once per frame, on the falling edge
// of VSYNC, so a scroll change never tears a visible frame.
//
// Parameters:
//   START_X, START_Y  first window column / line (inclusive)
//   READ_LATENCY      RAM clocks from fb_addr to valid fb_data (1..3)
//   BORDER_COLOR      RGB565 colour for active pixels outside the window
//
// Ports:
//   pixel_clk          pixel clock
//   rst                asynchronous, active-low reset
//   x, y               pixel / line counters from the timing generator
//   in_hsync, in_vsync active-low syncs from the timing generator
//   in_den             data enable from the timing generator
//   scroll_x, scroll_y requested scroll, taken at the VSYNC falling edge
//   fb_addr            framebuffer read address {row, col}
//   fb_rd_en           read strobe, high for in-window pixels only
//   fb_data            RAM read data, READ_LATENCY clocks after fb_addr
//   LCD_R/G/B          colour bus (5/6/5 bits)
//   LCD_HYNC, LCD_SYNC delayed HSYNC / VSYNC, active low
//   LCD_DEN            delayed data enable
//   frame_count        VSYNC falling edges seen since reset
module fb_window_renderer #(
  parameter logic [15:0] START_X      = 16'd192,
  parameter logic [15:0] START_Y      = 16'd112,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] BORDER_COLOR = 16'h0010
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_den,
  input  logic [7:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  output logic [15:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [15:0] fb_data,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        LCD_HYNC,
  output logic        LCD_SYNC,
  output logic        LCD_DEN,
  output logic [15:0] frame_count
);

  localparam logic [15:0] END_X      = START_X + 16'd256;
  localparam logic [15:0] END_Y      = START_Y + 16'd256;
  localparam logic [7:0]  START_X_LO = START_X[7:0];
  localparam logic [7:0]  START_Y_LO = START_Y[7:0];
  localparam int          TAP        = READ_LATENCY;

  logic        in_win;
  logic [7:0]  col;
  logic [7:0]  row;
  logic        frame_latch;

  logic [7:0]  sx_q;
  logic [7:0]  sy_q;
  logic        prev_vs_q;

  // Flag pipelines. Bit 0 is loaded together with fb_addr. Bit TAP lines up
  // with the cycle in which the RAM presents the matching fb_data.
  logic [TAP:0] win_pipe;
  logic [TAP:0] den_pipe;
  logic [TAP:0] hs_pipe;
  logic [TAP:0] vs_pipe;

  logic [15:0] color_q;

  // Only the low byte of (x - START_X) matters once the window test has
  // passed. Doing the subtraction in 8 bits gives the mod-256 wrap for free.
  always_comb begin
    in_win      = in_den
                  && (x >= START_X) && (x < END_X)
                  && (y >= START_Y) && (y < END_Y);
    col         = x[7:0] - START_X_LO + sx_q;
    row         = y[7:0] - START_Y_LO + sy_q;
    frame_latch = prev_vs_q && !in_vsync;
  end

  // The scroll and frame counter update on the VSYNC falling edge. The
  // address issued on that same edge still uses the previous scroll values.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      prev_vs_q   <= 1'b1;
      sx_q        <= 8'd0;
      sy_q        <= 8'd0;
      frame_count <= 16'd0;
    end else begin
      prev_vs_q <= in_vsync;
      if (frame_latch) begin
        sx_q        <= scroll_x;
        sy_q        <= scroll_y;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Outside the window the address holds its last value, so the RAM address
  // bus does not toggle during border and blanking pixels.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      fb_addr  <= 16'd0;
      fb_rd_en <= 1'b0;
    end else begin
      fb_rd_en <= in_win;
      if (in_win) begin
        fb_addr <= {row, col};
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      win_pipe <= '0;
      den_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      win_pipe <= {win_pipe[TAP-1:0], in_win};
      den_pipe <= {den_pipe[TAP-1:0], in_den};
      hs_pipe  <= {hs_pipe[TAP-1:0], in_hsync};
      vs_pipe  <= {vs_pipe[TAP-1:0], in_vsync};
    end
  end

  // The output register uses the flags from the tap that matches fb_data.
  // Colour, syncs and DEN therefore leave the block on the same edge.
  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      color_q  <= 16'd0;
      LCD_DEN  <= 1'b0;
      LCD_HYNC <= 1'b1;
      LCD_SYNC <= 1'b1;
    end else begin
      if (!den_pipe[TAP]) begin
        color_q <= 16'd0;
      end else if (!win_pipe[TAP]) begin
        color_q <= BORDER_COLOR;
      end else begin
        color_q <= fb_data;
      end
      LCD_DEN  <= den_pipe[TAP];
      LCD_HYNC <= hs_pipe[TAP];
      LCD_SYNC <= vs_pipe[TAP];
    end
  end

  assign LCD_R = color_q[15:11];
  assign LCD_G = color_q[10:5];
  assign LCD_B = color_q[4:0];

endmodule

// File: tb/tb_fb_window_renderer.sv
// tb_fb_window_renderer
//
// Three copies of fb_window_renderer (READ_LATENCY = 1, 2, 3) receive the
// same input stream. Each copy has its own RAM model, which returns the read
// address as the data word.
module tb_fb_window_renderer;

  localparam int          NDUT     = 3;
  localparam logic [15:0] BORDER   = 16'h0010;
  localparam int          LINE_LEN = 48;
  localparam int          NLINES   = 24;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        den;
    logic        hs;
    logic        vs;
    logic [7:0]  sx;
    logic [7:0]  sy;
  } in_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        den;
    logic        hs;
    logic        vs;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic [15:0] exp_addr;
    logic        exp_rd;
    logic [15:0] exp_color;
    logic [15:0] exp_frame;
  } vec_t;

  typedef struct {
    logic        den;
    logic        hs;
    logic        vs;
    logic [15:0] color;
  } out_t;

  logic        pixel_clk = 1'b0;
  logic        rst       = 1'b1;
  logic [15:0] x;
  logic [15:0] y;
  logic        in_hsync;
  logic        in_vsync;
  logic        in_den;
  logic [7:0]  scroll_x;
  logic [7:0]  scroll_y;

  logic [15:0] fb_addr     [1:NDUT];
  logic        fb_rd_en    [1:NDUT];
  logic [15:0] fb_data     [1:NDUT];
  logic [4:0]  lcd_r       [1:NDUT];
  logic [5:0]  lcd_g       [1:NDUT];
  logic [4:0]  lcd_b       [1:NDUT];
  logic        lcd_hync    [1:NDUT];
  logic        lcd_sync    [1:NDUT];
  logic        lcd_den     [1:NDUT];
  logic [15:0] frame_count [1:NDUT];

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state
  int   m_sx;
  int   m_sy;
  int   m_count;
  int   m_addr;
  bit   m_rd;
  bit   m_prev_vs;
  out_t exp_q[$];

  always #5 pixel_clk = ~pixel_clk;

  genvar g;
  generate
    for (g = 1; g <= NDUT; g = g + 1) begin : g_dut
      logic [15:0] ram_q [0:g-1];

      fb_window_renderer #(
        .START_X      (16'd192),
        .START_Y      (16'd112),
        .READ_LATENCY (g),
        .BORDER_COLOR (BORDER)
      ) u_dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .in_hsync    (in_hsync),
        .in_vsync    (in_vsync),
        .in_den      (in_den),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .fb_addr     (fb_addr[g]),
        .fb_rd_en    (fb_rd_en[g]),
        .fb_data     (fb_data[g]),
        .LCD_R       (lcd_r[g]),
        .LCD_G       (lcd_g[g]),
        .LCD_B       (lcd_b[g]),
        .LCD_HYNC    (lcd_hync[g]),
        .LCD_SYNC    (lcd_sync[g]),
        .LCD_DEN     (lcd_den[g]),
        .frame_count (frame_count[g])
      );

      // Synchronous RAM with g clocks of read latency. The data word equals
      // the address.
      always @(posedge pixel_clk) begin
        ram_q[0] <= fb_addr[g];
        for (int k = 1; k < g; k++) begin
          ram_q[k] <= ram_q[k-1];
        end
      end
      assign fb_data[g] = ram_q[g-1];
    end
  endgenerate

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input in_t v);
    x        = v.x;
    y        = v.y;
    in_den   = v.den;
    in_hsync = v.hs;
    in_vsync = v.vs;
    scroll_x = v.sx;
    scroll_y = v.sy;
  endtask

  function automatic in_t idle_vec();
    in_t v;
    v.x   = 16'd0;
    v.y   = 16'd0;
    v.den = 1'b0;
    v.hs  = 1'b1;
    v.vs  = 1'b1;
    v.sx  = 8'd0;
    v.sy  = 8'd0;
    return v;
  endfunction

  function automatic in_t random_vec();
    in_t v;
    v.x   = 16'($urandom);
    v.y   = 16'($urandom);
    v.den = 1'($urandom);
    v.hs  = 1'($urandom);
    v.vs  = 1'($urandom);
    v.sx  = 8'($urandom);
    v.sy  = 8'($urandom);
    return v;
  endfunction

  function automatic logic [15:0] gen_line_y();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      7:       return 16'd111 + 16'($urandom_range(0, 1));
      8:       return 16'd367 + 16'($urandom_range(0, 1));
      9:       return 16'($urandom);
      default: return 16'($urandom_range(100, 380));
    endcase
  endfunction

  // Compressed frame: VSYNC low for lines 0-1, HSYNC low for the first 4
  // clocks of every line, and DEN mostly high in the active part.
  function automatic in_t gen_pixel(input int line, input int p,
                                    input logic [15:0] line_y);
    in_t v;
    int  r;
    v.vs  = (line < 2) ? 1'b0 : 1'b1;
    v.hs  = (p < 4) ? 1'b0 : 1'b1;
    v.den = (line >= 4 && p >= 8) ? ($urandom_range(0, 7) != 0) : 1'b0;
    v.y   = line_y;
    r = int'($urandom_range(0, 9));
    case (r)
      7:       v.x = 16'd191 + 16'($urandom_range(0, 1));
      8:       v.x = 16'd447 + 16'($urandom_range(0, 1));
      9:       v.x = 16'($urandom);
      default: v.x = 16'($urandom_range(180, 460));
    endcase
    v.sx = 8'($urandom);
    v.sy = 8'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    out_t o;
    m_sx      = 0;
    m_sy      = 0;
    m_count   = 0;
    m_addr    = 0;
    m_rd      = 1'b0;
    m_prev_vs = 1'b1;
    o.den     = 1'b0;
    o.hs      = 1'b1;
    o.vs      = 1'b1;
    o.color   = 16'h0000;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(o);
  endtask

  // The model works out each pixel with plain arithmetic: a window test,
  // a mod-256 scrolled address, and the colour the LCD should show for it.
  task automatic model_step(input in_t v);
    int   xi;
    int   yi;
    bit   win;
    out_t o;
    xi  = int'(v.x);
    yi  = int'(v.y);
    win = v.den && xi >= 192 && xi < 448 && yi >= 112 && yi < 368;
    m_rd = win;
    if (win) m_addr = ((yi - 112 + m_sy) % 256) * 256 + ((xi - 192 + m_sx) % 256);
    o.den   = v.den;
    o.hs    = v.hs;
    o.vs    = v.vs;
    o.color = !v.den ? 16'h0000 : (!win ? BORDER : 16'(m_addr));
    exp_q.push_back(o);
    if (exp_q.size() > 8) void'(exp_q.pop_front());
    if (m_prev_vs && !v.vs) begin
      m_sx    = int'(v.sx);
      m_sy    = int'(v.sy);
      m_count = (m_count + 1) % 65536;
    end
    m_prev_vs = v.vs;
  endtask

  // Runs at a falling edge. The newest queue entry is the pixel sampled at
  // the previous rising edge. The copy with latency r shows the pixel
  // sampled r+2 edges ago.
  task automatic check_model();
    out_t o;
    for (int r = 1; r <= NDUT; r++) begin
      o = exp_q[exp_q.size() - r - 2];
      checkOutput($sformatf("fb_addr rl%0d", r), fb_addr[r], 16'(m_addr));
      checkOutput($sformatf("fb_rd_en rl%0d", r), 16'(fb_rd_en[r]), 16'(m_rd));
      checkOutput($sformatf("frame_count rl%0d", r), frame_count[r], 16'(m_count));
      checkOutput($sformatf("colour rl%0d", r), {lcd_r[r], lcd_g[r], lcd_b[r]}, o.color);
      checkOutput($sformatf("LCD_DEN rl%0d", r), 16'(lcd_den[r]), 16'(o.den));
      checkOutput($sformatf("LCD_HYNC rl%0d", r), 16'(lcd_hync[r]), 16'(o.hs));
      checkOutput($sformatf("LCD_SYNC rl%0d", r), 16'(lcd_sync[r]), 16'(o.vs));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int r = 1; r <= NDUT; r++) begin
      checkOutput($sformatf("%s fb_addr rl%0d", tag, r), fb_addr[r], 16'h0000);
      checkOutput($sformatf("%s fb_rd_en rl%0d", tag, r), 16'(fb_rd_en[r]), 16'h0000);
      checkOutput($sformatf("%s colour rl%0d", tag, r), {lcd_r[r], lcd_g[r], lcd_b[r]}, 16'h0000);
      checkOutput($sformatf("%s LCD_DEN rl%0d", tag, r), 16'(lcd_den[r]), 16'h0000);
      checkOutput($sformatf("%s LCD_HYNC rl%0d", tag, r), 16'(lcd_hync[r]), 16'h0001);
      checkOutput($sformatf("%s LCD_SYNC rl%0d", tag, r), 16'(lcd_sync[r]), 16'h0001);
      checkOutput($sformatf("%s frame_count rl%0d", tag, r), frame_count[r], 16'h0000);
    end
  endtask

  task automatic run_frames(input int n_frames, input int reset_frame,
                            input int reset_line);
    in_t         v;
    logic [15:0] line_y;
    for (int f = 0; f < n_frames; f++) begin
      for (int line = 0; line < NLINES; line++) begin
        line_y = gen_line_y();
        for (int p = 0; p < LINE_LEN; p++) begin
          @(negedge pixel_clk);
          check_model();
          if (f == reset_frame && line == 2 && p == 0)
            checkOutput("frames before reset", frame_count[1], 16'(reset_frame + 1));
          if (f == reset_frame + 1 && line == 2 && p == 0)
            checkOutput("first frame after reset", frame_count[1], 16'h0001);
          if (f == reset_frame && line == reset_line && p == 20) begin
            #2 rst = 1'b0;
            #1 check_reset_state("midframe async");
            @(negedge pixel_clk);
            check_reset_state("midframe held");
            rst = 1'b1;
            model_reset();
          end
          v = gen_pixel(line, p, line_y);
          applyStimulus(v);
          model_step(v);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [14];
    in_t  v;

    //          x          y         den   hs    vs    sx     sy     addr      rd    colour    frame
    tbl[0]  = '{16'd191,   16'd112, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b0, 16'h0010, 16'd0};
    tbl[1]  = '{16'd192,   16'd112, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 16'h0000, 1'b1, 16'h0000, 16'd0};
    tbl[2]  = '{16'd447,   16'd367, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b1, 16'hFFFF, 16'd0};
    tbl[3]  = '{16'd448,   16'd367, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b0, 16'h0010, 16'd0};
    tbl[4]  = '{16'd300,   16'd200, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b0, 16'h0000, 16'd0};
    tbl[5]  = '{16'd300,   16'd111, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b0, 16'h0010, 16'd0};
    tbl[6]  = '{16'd300,   16'd368, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 16'hFFFF, 1'b0, 16'h0010, 16'd0};
    tbl[7]  = '{16'd200,   16'd120, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 16'h0808, 1'b1, 16'h0808, 16'd0};
    tbl[8]  = '{16'd0,     16'd0,   1'b0, 1'b1, 1'b0, 8'hF0, 8'h20, 16'h0808, 1'b0, 16'h0000, 16'd1};
    tbl[9]  = '{16'd212,   16'd112, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 16'h2004, 1'b1, 16'h2004, 16'd1};
    tbl[10] = '{16'd447,   16'd367, 1'b1, 1'b1, 1'b1, 8'h55, 8'h66, 16'h1FEF, 1'b1, 16'h1FEF, 16'd1};
    tbl[11] = '{16'd0,     16'd0,   1'b0, 1'b1, 1'b0, 8'h01, 8'hFF, 16'h1FEF, 1'b0, 16'h0000, 16'd2};
    tbl[12] = '{16'd192,   16'd112, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 16'hFF01, 1'b1, 16'hFF01, 16'd2};
    tbl[13] = '{16'hFFFF,  16'd112, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 16'hFF01, 1'b0, 16'h0010, 16'd2};

    applyStimulus(idle_vec());
    #1 rst = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge pixel_clk);
      check_reset_state("reset");
      applyStimulus(random_vec());
    end

    @(negedge pixel_clk);
    rst = 1'b1;
    model_reset();
    applyStimulus(idle_vec());
    model_step(idle_vec());

    // Single-pixel probes, with idle pixels in between
    for (int i = 0; i < 14; i++) begin
      v.x  = tbl[i].x;
      v.y  = tbl[i].y;
      v.den = tbl[i].den;
      v.hs = tbl[i].hs;
      v.vs = tbl[i].vs;
      v.sx = tbl[i].sx;
      v.sy = tbl[i].sy;
      applyStimulus(v);
      for (int k = 1; k <= 5; k++) begin
        @(negedge pixel_clk);
        if (k == 1) begin
          for (int r = 1; r <= NDUT; r++) begin
            checkOutput($sformatf("tbl%0d fb_addr rl%0d", i, r), fb_addr[r], tbl[i].exp_addr);
            checkOutput($sformatf("tbl%0d fb_rd_en rl%0d", i, r), 16'(fb_rd_en[r]), 16'(tbl[i].exp_rd));
            checkOutput($sformatf("tbl%0d frame_count rl%0d", i, r), frame_count[r], tbl[i].exp_frame);
          end
        end
        if (k >= 3) begin
          checkOutput($sformatf("tbl%0d colour rl%0d", i, k - 2),
                      {lcd_r[k-2], lcd_g[k-2], lcd_b[k-2]}, tbl[i].exp_color);
          checkOutput($sformatf("tbl%0d LCD_DEN rl%0d", i, k - 2), 16'(lcd_den[k-2]), 16'(tbl[i].den));
          checkOutput($sformatf("tbl%0d LCD_HYNC rl%0d", i, k - 2), 16'(lcd_hync[k-2]), 16'(tbl[i].hs));
          checkOutput($sformatf("tbl%0d LCD_SYNC rl%0d", i, k - 2), 16'(lcd_sync[k-2]), 16'(tbl[i].vs));
        end
        applyStimulus(idle_vec());
      end
    end

    // Clean restart before the randomized frames
    @(negedge pixel_clk);
    rst = 1'b0;
    @(negedge pixel_clk);
    check_reset_state("restart");
    rst = 1'b1;
    model_reset();
    applyStimulus(idle_vec());
    model_step(idle_vec());

    // Three clean frames, a fourth frame reset at line 12, and one more frame
    run_frames(5, 3, 12);

    @(negedge pixel_clk);
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
